tcm_mul_sequencer: RTL

//  Sequences a 4-way-split binary-polynomial (GF(2)[x]) multiply c = a*b over one shared bit-serial limb engine.

---
 rtl/tcm_mul_if.sv | 9 +
 rtl/tcm_mul_sequencer.sv | 93 +++++++++
 2 files changed

// File: rtl/tcm_mul_if.sv
// tcm_mul_if: operand/result handshake bundle for tcm_mul_sequencer.
interface tcm_mul_if #(parameter int W = 409);
    logic in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0] a, b;
    logic [2*W-1:0] c;
    logic [3:0] pair_idx;
    modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, c, busy, pair_idx);
    modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, c, busy, pair_idx);
endinterface

// File: rtl/tcm_mul_sequencer.sv
// tcm_mul_sequencer: 4x4-limb GF(2)[x] multiply over one bit-serial limb engine.
// Define SKIP_ZERO_LIMB_EN to skip pairs whose a limb is zero (data-dependent latency).
module tcm_mul_sequencer #(
    parameter int W = 409,
    parameter int LIMB = 103
) (
    input logic clk,
    input logic rst,
    tcm_mul_if.slave bus
);
    localparam int L4 = 4 * LIMB;
    localparam int KW = $clog2(LIMB);
    typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, DONE} state_t;
    state_t state, state_n;
    logic [L4-1:0] a_r, b_r;
    logic [2*LIMB-2:0] pp;
    logic [2*L4-1:0] acc, acc_n;
    logic [KW-1:0] k;
    logic [3:0] pair_idx;
    logic [2*W-1:0] c_r;
    logic [LIMB-1:0] a_limb, b_limb;
    logic last_bit, last_pair, skip;
    int sh;
    assign a_limb = a_r[LIMB*int'(pair_idx[3:2]) +: LIMB];
    assign b_limb = b_r[LIMB*int'(pair_idx[1:0]) +: LIMB];
    assign last_bit = k == KW'(LIMB - 1);
    assign last_pair = pair_idx == 4'd15;
    assign sh = LIMB * (int'(pair_idx[3:2]) + int'(pair_idx[1:0]));
    assign acc_n = acc ^ ((2*L4)'(pp) << sh);
`ifdef SKIP_ZERO_LIMB_EN
    // only decided on the first cycle of a pair, so a skip costs exactly one cycle
    assign skip = k == '0 && a_limb == '0;
`else
    assign skip = 1'b0;
`endif
    assign bus.c = c_r;
    assign bus.pair_idx = pair_idx;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: state_n = bus.in_valid ? LOAD : IDLE;
            LOAD: state_n = MUL;
            MUL: state_n = skip ? (last_pair ? DONE : MUL) : (last_bit ? ACC : MUL);
            ACC: state_n = last_pair ? DONE : MUL;
            DONE: state_n = bus.out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
        bus.in_ready = state == IDLE;
        bus.out_valid = state == DONE;
        bus.busy = state != IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            pp <= '0;
            acc <= '0;
            k <= '0;
            pair_idx <= '0;
            c_r <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    a_r <= L4'(bus.a);
                    b_r <= L4'(bus.b);
                end
                LOAD: begin
                    acc <= '0;
                    pp <= '0;
                    k <= '0;
                    pair_idx <= '0;
                end
                MUL: if (skip) begin
                    pair_idx <= last_pair ? pair_idx : pair_idx + 4'd1;
                    if (last_pair) c_r <= acc[2*W-1:0];
                end else begin
                    if (a_limb[k]) pp <= pp ^ ((2*LIMB-1)'(b_limb) << k);
                    k <= k + KW'(1);
                end
                ACC: begin
                    acc <= acc_n;
                    pp <= '0;
                    k <= '0;
                    if (last_pair) c_r <= acc_n[2*W-1:0];
                    else pair_idx <= pair_idx + 4'd1;
                end
                default: ;
            endcase
        end
endmodule
